// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver (optional parity, 1/2 stop bits) feeding a first-word-fall-through FIFO.
// Line errors are latched in sticky flags until clr_err; the FSM state is exported as rx_state_out.
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx,
    input  logic                            rd_en,
    input  logic                            clr_err,
    output logic [DATA_BITS-1:0]            rd_data,
    output logic                            rd_valid,
    output logic                            fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun,
    output logic [2:0]                      rx_state_out
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic          ODD       = 1'(PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_PUSH      = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } state_t;

    state_t               state_reg, state_next;
    logic                 rx_meta_reg, rxs;
    logic [BW-1:0]        baud_cnt_reg;
    logic                 tick, mid_bit, start_entry;
    logic [SW-1:0]        samp_reg, samp_next;
    logic [3:0]           bit_reg, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 bad_reg, bad_next;
    logic                 push, pop, set_frame, set_parity, set_overrun;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]        count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rxs         <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rxs         <= rx_meta_reg;
        end
    end

    // Oversample tick; phase is realigned to the falling edge that starts a frame.
    assign tick    = (baud_cnt_reg == BAUD_LAST);
    assign mid_bit = tick && (samp_reg == FULL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            baud_cnt_reg <= '0;
        else if (start_entry || tick)
            baud_cnt_reg <= '0;
        else
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
    end

    always_comb begin
        state_next  = state_reg;
        samp_next   = samp_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        bad_next    = bad_reg;
        start_entry = 1'b0;
        push        = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
        set_overrun = 1'b0;
        if (tick && (state_reg inside {ST_DATA, ST_PARITY, ST_STOP}))
            samp_next = mid_bit ? '0 : samp_reg + 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (!rxs) begin
                    state_next  = ST_START;
                    samp_next   = '0;
                    bit_next    = '0;
                    bad_next    = 1'b0;
                    start_entry = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (samp_reg == HALF_LAST) begin
                        samp_next  = '0;
                        state_next = rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        samp_next = samp_reg + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (mid_bit) begin
                    shift_next = {rxs, shift_reg[DATA_BITS-1:1]};
                    if (bit_reg == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (mid_bit) begin
                    bad_next   = (^shift_reg) ^ rxs ^ ODD;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mid_bit) begin
                    if (!rxs) begin
                        set_frame  = 1'b1;
                        state_next = ST_WAIT_IDLE;
                    end else if (bit_reg == STOP_LAST) begin
                        state_next = ST_PUSH;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            ST_PUSH: begin
                state_next = ST_IDLE;
                if (bad_reg)
                    set_parity = 1'b1;
                else if (fifo_full && !rd_en)
                    set_overrun = 1'b1;
                else
                    push = 1'b1;
            end
            ST_WAIT_IDLE: begin
                if (rxs)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            samp_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            bad_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            samp_reg  <= samp_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            bad_reg   <= bad_next;
        end
    end

    // FIFO: a pop on an empty FIFO is dropped, so push+pop when empty only pushes.
    assign pop = rd_en && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= shift_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= set_frame   | (frame_err  & ~clr_err);
            parity_err <= set_parity  | (parity_err & ~clr_err);
            overrun    <= set_overrun | (overrun    & ~clr_err);
        end
    end

    assign rd_valid     = (count_reg != '0);
    assign fifo_full    = (count_reg == DEPTH_C);
    assign fifo_count   = count_reg;
    assign rd_data      = rd_valid ? mem[rd_ptr_reg] : '0;
    assign rx_state_out = state_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E2 instance, each checked every idle cycle
// against a frame-level queue model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int BIT_CLK = 32;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]      rx, rd_en, clr_err;
    logic [1:0][7:0] rd_data;
    logic [1:0]      rd_valid, fifo_full, frame_err, parity_err, overrun;
    logic [1:0][2:0] fifo_count, state;

    int errors = 0;
    int checks = 0;

    logic [7:0]      q0[$];
    logic [7:0]      q1[$];
    logic [1:0]      m_fe, m_pe, m_ov;
    logic [1:0][2:0] m_state;
    logic [1:0]      settled;

    logic [2:0] trace[$];
    logic [2:0] last_st;
    logic       trace_on;

    always #5 clk = ~clk;

    uart_rx_fifo #(.BAUD_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .rx(rx[0]), .rd_en(rd_en[0]), .clr_err(clr_err[0]),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .fifo_full(fifo_full[0]),
        .fifo_count(fifo_count[0]), .frame_err(frame_err[0]), .parity_err(parity_err[0]),
        .overrun(overrun[0]), .rx_state_out(state[0])
    );

    uart_rx_fifo #(.BAUD_DIV(2), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .rx(rx[1]), .rd_en(rd_en[1]), .clr_err(clr_err[1]),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .fifo_full(fifo_full[1]),
        .fifo_count(fifo_count[1]), .frame_err(frame_err[1]), .parity_err(parity_err[1]),
        .overrun(overrun[1]), .rx_state_out(state[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_count(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int m_head(input int u);
        if (m_count(u) == 0) return 0;
        return (u == 0) ? int'(q0[0]) : int'(q1[0]);
    endfunction

    task automatic m_push(input int u, input logic [7:0] d);
        if (u == 0) q0.push_back(d); else q1.push_back(d);
    endtask

    task automatic m_pop(input int u);
        if (m_count(u) != 0) begin
            if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    // Outcome of one complete frame: stop error beats parity error beats overrun.
    task automatic model_frame(input int u, input logic [7:0] d, input logic pbit, input logic stop_ok);
        if (!stop_ok)
            m_fe[u] = 1'b1;
        else if (u == 1 && (^{d, pbit}) != 1'b0)
            m_pe[u] = 1'b1;
        else if (m_count(u) == DEPTH)
            m_ov[u] = 1'b1;
        else
            m_push(u, d);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int u = 0; u < 2; u++) begin
                if (settled[u]) begin
                    check($sformatf("u%0d rd_valid", u), 32'(rd_valid[u]), 32'(m_count(u) != 0));
                    check($sformatf("u%0d fifo_count", u), 32'(fifo_count[u]), m_count(u));
                    check($sformatf("u%0d fifo_full", u), 32'(fifo_full[u]), 32'(m_count(u) == DEPTH));
                    if (m_count(u) != 0)
                        check($sformatf("u%0d rd_data", u), 32'(rd_data[u]), m_head(u));
                    check($sformatf("u%0d frame_err", u), 32'(frame_err[u]), 32'(m_fe[u]));
                    check($sformatf("u%0d parity_err", u), 32'(parity_err[u]), 32'(m_pe[u]));
                    check($sformatf("u%0d overrun", u), 32'(overrun[u]), 32'(m_ov[u]));
                    check($sformatf("u%0d state", u), 32'(state[u]), 32'(m_state[u]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!trace_on)
            last_st <= 3'd0;
        else if (state[0] != last_st) begin
            trace.push_back(state[0]);
            last_st <= state[0];
        end
    end

    // All driving tasks start and end 1 ns after a rising edge.
    task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                              input logic [1:0] stops, input int hold_low);
        logic [11:0] bits;
        int          n;
        logic        stop_ok;
        settled[u] = 1'b0;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        if (u == 0) begin
            bits[9] = stops[0];
            n = 10;
            stop_ok = stops[0];
        end else begin
            bits[9]  = pbit;
            bits[10] = stops[0];
            bits[11] = stops[1];
            n = 12;
            stop_ok = stops[0] & stops[1];
        end
        for (int i = 0; i < n; i++) begin
            rx[u] = bits[i];
            repeat (BIT_CLK) @(posedge clk);
            #1;
        end
        model_frame(u, d, pbit, stop_ok);
        if (!stop_ok && hold_low > 0) begin
            rx[u] = 1'b0;
            m_state[u] = 3'd6;
            repeat (6) @(posedge clk);
            #1;
            settled[u] = 1'b1;
            repeat (hold_low) @(posedge clk);
            #1;
            check("wait_idle state", 32'(state[u]), 32'd6);
            settled[u] = 1'b0;
        end
        rx[u] = 1'b1;
        m_state[u] = 3'd0;
        repeat (6) @(posedge clk);
        #1;
        settled[u] = 1'b1;
    endtask

    task automatic do_read(input int u);
        rd_en[u] = 1'b1;
        @(posedge clk);
        #1;
        rd_en[u] = 1'b0;
        m_pop(u);
    endtask

    task automatic do_clr(input int u);
        clr_err[u] = 1'b1;
        @(posedge clk);
        #1;
        clr_err[u] = 1'b0;
        m_fe[u] = 1'b0;
        m_pe[u] = 1'b0;
        m_ov[u] = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s u%0d rd_valid", tag, u), 32'(rd_valid[u]), 32'd0);
            check($sformatf("%s u%0d rd_data", tag, u), 32'(rd_data[u]), 32'd0);
            check($sformatf("%s u%0d fifo_full", tag, u), 32'(fifo_full[u]), 32'd0);
            check($sformatf("%s u%0d fifo_count", tag, u), 32'(fifo_count[u]), 32'd0);
            check($sformatf("%s u%0d flags", tag, u),
                  32'({frame_err[u], parity_err[u], overrun[u]}), 32'd0);
            check($sformatf("%s u%0d state", tag, u), 32'(state[u]), 32'd0);
        end
    endtask

    initial begin
        int          exp_tr[5];
        int          exp_gl[2];
        int          u, r, k;
        logic [7:0]  d;
        logic        pbit, found;
        logic [1:0]  st;

        rst = 1'b1; rx = 2'b11; rd_en = 2'b00; clr_err = 2'b00;
        settled = 2'b00; trace_on = 1'b0;
        m_fe = '0; m_pe = '0; m_ov = '0; m_state = '0;
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        settled = 2'b11;

        // 8N1 byte and its state trace
        trace.delete();
        trace_on = 1'b1;
        send_frame(0, 8'hA5, 1'b0, 2'b11, 0);
        trace_on = 1'b0;
        check("a5 rd_data", 32'(rd_data[0]), 32'hA5);
        check("a5 count", 32'(fifo_count[0]), 32'd1);
        exp_tr = '{1, 2, 4, 5, 0};
        check("a5 trace len", trace.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < trace.size()) check($sformatf("a5 trace[%0d]", i), 32'(trace[i]), exp_tr[i]);
        do_read(0);

        // fill, overrun, drain in order
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 8'(8'h11 * i), 1'b0, 2'b11, 0);
            if (i == 4) check("fill full", 32'(fifo_full[0]), 32'd1);
        end
        check("fill overrun", 32'(overrun[0]), 32'd1);
        check("fill count", 32'(fifo_count[0]), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain %0d", i), 32'(rd_data[0]), 32'(8'h11 * i));
            do_read(0);
        end
        check("drain count", 32'(fifo_count[0]), 32'd0);
        do_clr(0);
        check("clr overrun", 32'(overrun[0]), 32'd0);

        // even parity on the 8E2 instance
        send_frame(1, 8'h03, 1'b0, 2'b11, 0);
        check("par good count", 32'(fifo_count[1]), 32'd1);
        send_frame(1, 8'h03, 1'b1, 2'b11, 0);
        check("par bad flag", 32'(parity_err[1]), 32'd1);
        check("par bad count", 32'(fifo_count[1]), 32'd1);
        do_clr(1);
        check("par clr", 32'(parity_err[1]), 32'd0);
        do_read(1);

        // line break: frame error, held in WAIT_IDLE, then a clean byte
        send_frame(0, 8'h5A, 1'b0, 2'b00, 3 * BIT_CLK);
        check("brk frame_err", 32'(frame_err[0]), 32'd1);
        check("brk count", 32'(fifo_count[0]), 32'd0);
        send_frame(0, 8'h7E, 1'b0, 2'b11, 0);
        check("after brk data", 32'(rd_data[0]), 32'h7E);
        do_read(0);
        do_clr(0);

        // short glitch: START then back to IDLE
        settled[0] = 1'b0;
        trace.delete();
        trace_on = 1'b1;
        rx[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        trace_on = 1'b0;
        settled[0] = 1'b1;
        exp_gl = '{1, 0};
        check("glitch trace len", trace.size(), 32'd2);
        for (int i = 0; i < 2; i++)
            if (i < trace.size()) check($sformatf("glitch trace[%0d]", i), 32'(trace[i]), exp_gl[i]);

        // full FIFO with a read landing exactly on the PUSH cycle
        for (int i = 0; i < 4; i++) send_frame(0, 8'(8'hB1 + i), 1'b0, 2'b11, 0);
        check("pre-push full", 32'(fifo_full[0]), 32'd1);
        found = 1'b0;
        fork
            send_frame(0, 8'hC6, 1'b0, 2'b11, 0);
            begin
                k = 0;
                while (k < 600 && !found) begin
                    @(negedge clk);
                    k++;
                    if (state[0] == 3'd5) found = 1'b1;
                end
                if (found) begin
                    rd_en[0] = 1'b1;
                    @(posedge clk);
                    #1;
                    rd_en[0] = 1'b0;
                    m_pop(0);
                end
            end
        join
        check("push state seen", 32'(found), 32'd1);
        check("push+pop count", 32'(fifo_count[0]), 32'd4);
        check("push+pop overrun", 32'(overrun[0]), 32'd0);
        check("push+pop head", 32'(rd_data[0]), 32'hB2);

        // asynchronous reset in the middle of a frame
        settled = 2'b00;
        rx[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        reset_checks("midreset");
        q0.delete(); q1.delete();
        m_fe = '0; m_pe = '0; m_ov = '0; m_state = '0;
        rx = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        settled = 2'b11;

        // randomized frames, reads and clears on both instances
        for (int it = 0; it < 40; it++) begin
            u = int'($urandom_range(0, 1));
            d = 8'($urandom);
            r = int'($urandom_range(0, 9));
            pbit = ^d;
            st = 2'b11;
            if (r == 0) st[$urandom_range(0, 1)] = 1'b0;
            if (r == 1) pbit = ~pbit;
            send_frame(u, d, pbit, st, 0);
            k = int'($urandom_range(0, 2));
            for (int j = 0; j < k; j++) do_read(u);
            if ($urandom_range(0, 7) == 0) do_clr(u);
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with an oversampled bit clock, optional parity, 1 or 2 stop bits, and a receive FIFO. It replaces the fixed 8N1 receiver behind the core's memory-mapped UART. The core drains bytes through a first-word-fall-through read port, and error conditions are held in sticky flags. The FSM state is exported so it can be observed from the top level.

Parameters:
BAUD_DIV, 27, clk cycles per oversample tick (>=1)
OVERSAMPLE, 16, ticks per bit (even, >=4)
DATA_BITS, 8, data bits per frame (5..9)
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, entries, power of 2 (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rx  in  1  serial line, idle high, asynchronous
rd_en  in  1  pop head entry when rd_valid=1
clr_err  in  1  one-cycle pulse, clears sticky error flags
rd_data  out  DATA_BITS  FIFO head, valid when rd_valid=1
rd_valid  out  1  FIFO not empty
fifo_full  out  1  count == FIFO_DEPTH
fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held
frame_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: a good byte was dropped because the FIFO was full
rx_state_out  out  3  FSM state code

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE and the FIFO empties. Outputs: rd_data=0, rd_valid=0, fifo_full=0, fifo_count=0, all error flags 0, rx_state_out=0. The rx synchroniser flops reset to 1. Tick counter resets to 0. Reset mid-frame discards the partial frame.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- Tick generator: free-running counter 0..BAUD_DIV-1 that pulses tick for one clk on terminal count. It restarts at 0 on entry to START.
- State codes: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, PUSH=5, WAIT_IDLE=6.
- IDLE: when rxs=0, go to START and clear the sample counter.
- START: count ticks. At OVERSAMPLE/2 ticks:
  - rxs=0: go to DATA with sample counter 0.
  - rxs=1: treat as a glitch and return to IDLE; no flag is set.
- DATA: sample rxs every OVERSAMPLE ticks, i.e. at mid-bit. Shift in LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: sample at mid-bit and compute xor(data, parity bit). Mismatch is 1 for even parity, 0 for odd. A mismatch sets the internal bad flag.
- STOP: sample STOP_BITS times, each OVERSAMPLE ticks apart.
  - Any stop sample 0: set frame_err, discard the byte, go to WAIT_IDLE.
  - Otherwise go to PUSH.
- PUSH (1 clk):
  - If bad is set: set parity_err and discard the byte.
  - Else if the FIFO is full and rd_en=0: set overrun and discard the byte.
  - Else write the byte.
  - Then go to IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE. This prevents a line break from being seen as repeated frames.
- Byte latency: the byte is visible on rd_data no later than 2 clk after PUSH. That is 1 clk for the write plus fall-through. It is measured from the final mid-stop sample.
- FIFO:
  - rd_data always presents the head entry.
  - rd_en with rd_valid=0 is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: both occur and count is unchanged, including when full (no overrun).
  - Simultaneous push and pop when empty: the push lands and the pop is ignored.
- Error flags:
  - Once set, a flag stays 1 until a clr_err pulse.
  - clr_err in the same cycle as a new error: the flag ends at 1 (set wins).
  - Flags never block reception.
- Unused rd_data upper bits do not exist; width is exactly DATA_BITS.

Test Plan:
- Defaults except BAUD_DIV=2 (32 clk/bit). Send 0xA5 in 8N1 -> rd_valid=1 with rd_data=8'hA5, fifo_count=1, no flags. rx_state_out passes through 1,2,4,5,0.
- Send 0x11,0x22,0x33,0x44,0x55 with no reads (DEPTH=4) -> fifo_full=1 after the 4th byte, overrun=1 after the 5th. Then 4 rd_en pulses return 0x11..0x44 in order, ending with fifo_count=0.
- PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 0 -> accepted. Send 0x03 with parity bit 1 -> parity_err=1 and fifo_count unchanged. A clr_err pulse then clears it.
- Send 0x5A with stop bit 0 and hold rx low for 3 bit times -> frame_err=1, no push, FSM stays in WAIT_IDLE (6) until rx rises. The next valid 0x7E is then received correctly.
- rx low pulse of 4 clk (shorter than half a bit) -> FSM goes START then IDLE, nothing pushed, no flags.
- With FIFO full, hold rd_en=1 during the PUSH cycle of a 6th byte -> no overrun and fifo_count stays 4. Then assert rst=0 mid-frame -> all outputs return to reset values immediately.
